// File: rtl/race_lights_pkg.sv
// Shared types and constants for the race start light scheduler.
package race_lights_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRedHold = 3'd1,
        StYellow  = 3'd2,
        StGreen   = 3'd3,
        StFault   = 3'd4
    } state_e;

    localparam logic [1:0] CfgRed    = 2'd0;
    localparam logic [1:0] CfgYellow = 2'd1;
    localparam logic [1:0] CfgGreen  = 2'd2;
    localparam logic [1:0] CfgFault  = 2'd3;

    localparam int unsigned TRedDef    = 1;
    localparam int unsigned TYellowDef = 1;
    localparam int unsigned TGreenDef  = 3;
    localparam int unsigned TFaultDef  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after the last-granted lane.
module rr_arbiter #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned PW        = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req_i,
    input  logic [PW-1:0]        ptr_i,
    output logic [NUM_LANES-1:0] gnt_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_LANES; i++) begin
            idx = PW'((32'(ptr_i) + i) % NUM_LANES);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/race_start_scheduler.sv
// Arbitrates lanes onto one shared set of race lights and runs the timed start sequence.
module race_start_scheduler
    import race_lights_pkg::*;
#(
    parameter int unsigned NUM_LANES    = 4,
    parameter int unsigned TW           = 4,
    parameter int unsigned T_RED_DEF    = TRedDef,
    parameter int unsigned T_YELLOW_DEF = TYellowDef,
    parameter int unsigned T_GREEN_DEF  = TGreenDef,
    parameter int unsigned T_FAULT_DEF  = TFaultDef
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [NUM_LANES-1:0] REQ,
    input  logic [NUM_LANES-1:0] GO,
    input  logic                 ABORT,
    input  logic                 CFG_WE,
    input  logic [1:0]           CFG_SEL,
    input  logic [TW-1:0]        CFG_DATA,
    output logic [NUM_LANES-1:0] GRANT,
    output logic                 RED,
    output logic                 YELLOW,
    output logic                 GREEN,
    output logic                 FAULT,
    output logic                 DONE,
    output logic [NUM_LANES-1:0] FS_LANE
);

    localparam int unsigned PW = $clog2(NUM_LANES);

    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [NUM_LANES-1:0] grant_q, grant_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic                 done_q, done_d;
    logic [NUM_LANES-1:0] fs_q, fs_d;
    logic [TW-1:0]        hold_q [4];
    logic [TW-1:0]        hold_d [4];

    logic [NUM_LANES-1:0] arb_gnt;
    logic [PW-1:0]        gnt_idx;
    logic [TW-1:0]        cur_hold, hold_last;
    logic                 expire, false_start;

    rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .PW        (PW)
    ) u_rr_arbiter (
        .req_i (REQ),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (grant_q[i]) gnt_idx = PW'(i);
        end
    end

    always_comb begin
        case (state_q)
            StYellow: cur_hold = hold_q[CfgYellow];
            StGreen:  cur_hold = hold_q[CfgGreen];
            StFault:  cur_hold = hold_q[CfgFault];
            default:  cur_hold = hold_q[CfgRed];
        endcase
        // A zero hold behaves like a one-cycle hold.
        hold_last   = (cur_hold == '0) ? '0 : cur_hold - TW'(1);
        expire      = (timer_q == hold_last);
        false_start = ((state_q == StRedHold) || (state_q == StYellow)) && |(GO & grant_q);
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        fs_d    = '0;
        hold_d  = hold_q;
        case (state_q)
            StIdle: begin
                timer_d = '0;
                grant_d = '0;
                if (CFG_WE) hold_d[CFG_SEL] = CFG_DATA;
                if (|REQ) begin
                    grant_d = arb_gnt;
                    state_d = StRedHold;
                end
            end
            StRedHold, StYellow, StGreen, StFault: begin
                if (ABORT) begin
                    state_d = StIdle;
                    timer_d = '0;
                    grant_d = '0;
                end else if (false_start) begin
                    state_d = StFault;
                    timer_d = '0;
                    fs_d    = grant_q;
                    grant_d = '0;
                    ptr_d   = gnt_idx;
                end else if (expire) begin
                    timer_d = '0;
                    case (state_q)
                        StRedHold: state_d = StYellow;
                        StYellow:  state_d = StGreen;
                        StGreen: begin
                            state_d = StIdle;
                            grant_d = '0;
                            ptr_d   = gnt_idx;
                            done_d  = 1'b1;
                        end
                        default:   state_d = StIdle;
                    endcase
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
                grant_d = '0;
            end
        endcase
    end

    // State is updated on the falling edge of the system clock.
    always_ff @(negedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q           <= StIdle;
            timer_q           <= '0;
            grant_q           <= '0;
            ptr_q             <= PW'(NUM_LANES - 1);
            done_q            <= 1'b0;
            fs_q              <= '0;
            hold_q[CfgRed]    <= TW'(T_RED_DEF);
            hold_q[CfgYellow] <= TW'(T_YELLOW_DEF);
            hold_q[CfgGreen]  <= TW'(T_GREEN_DEF);
            hold_q[CfgFault]  <= TW'(T_FAULT_DEF);
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            fs_q    <= fs_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        RED    = 1'b0;
        YELLOW = 1'b0;
        GREEN  = 1'b0;
        FAULT  = 1'b0;
        case (state_q)
            StYellow: YELLOW = 1'b1;
            StGreen:  GREEN  = 1'b1;
            StFault: begin
                RED   = 1'b1;
                FAULT = 1'b1;
            end
            default:  RED    = 1'b1;
        endcase
    end

    assign GRANT   = grant_q;
    assign DONE    = done_q;
    assign FS_LANE = fs_q;

endmodule
